// File: rtl/ifetch_pkg.sv
// ifetch_pkg
//   Shared definitions for the instruction fetch sequencer:
//   - state_e       : fetch FSM states
//   - LONG_OP_PREFIX: opcode[7:5] value marking a two-byte instruction
//   - DEF_HALT_*    : default HALT opcode / compare mask
//   - is_two_byte() : length decode of an opcode byte
package ifetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_ARG,
        ST_ISSUE,
        ST_HALT
    } state_e;

    localparam logic [2:0] LONG_OP_PREFIX  = 3'b001;
    localparam logic [7:0] DEF_HALT_OPCODE = 8'h10;
    localparam logic [7:0] DEF_HALT_MASK   = 8'hF0;

    function automatic logic is_two_byte(input logic [7:0] opcode);
        return (opcode[7:5] == LONG_OP_PREFIX);
    endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// ifetch_pc_reg
//   Program counter register with load and modulo-2^ADDR_W increment.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (pc -> 0)
//     load        : load load_addr (has priority over inc)
//     load_addr   : PC target
//     inc         : advance PC by one, wrapping from all-ones to zero
//     pc          : current PC
//     wrap        : PC is all-ones, so an increment now would wrap to zero
module ifetch_pc_reg #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              wrap
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc   = pc_q;
    // Independent of inc/load so the FSM can consult it without a combinational loop.
    assign wrap = (pc_q == '1);

endmodule

// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer
//   Fetch controller for a 32 x 8 instruction ROM. Owns the PC, assembles
//   one- and two-byte instructions and hands them to the decoder over a
//   valid/ready handshake. Execute can redirect the PC; a HALT opcode stops
//   fetch until reset.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     run             : start fetching from current PC (sampled in IDLE)
//     imem_addr       : ROM address (always equals the PC)
//     imem_data       : ROM read data, combinational from imem_addr
//     inst_valid      : instruction presented
//     inst_ready      : decoder accepts the instruction
//     inst_opcode     : first instruction byte
//     inst_operand    : second byte, 0 for one-byte instructions
//     inst_len        : 0 = one byte, 1 = two bytes
//     inst_pc         : address of the opcode byte
//     redirect_valid  : load redirect_addr into the PC
//     redirect_addr   : redirect target
//     halted          : HALT state reached (sticky until reset)
//     fault           : PC wrap trap
//   Build option:
//     IFETCH_WRAP_TRAP_EN : when defined, a PC increment from all-ones to
//                           zero halts fetch with fault=1; otherwise the
//                           wrap is silent and fault stays 0.
module ifetch_sequencer
    import ifetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 5,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE,
    parameter logic [DATA_W-1:0] HALT_MASK   = DEF_HALT_MASK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_opcode,
    output logic [DATA_W-1:0] inst_operand,
    output logic              inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic              fault
);

`ifdef IFETCH_WRAP_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e            state_d,  state_q;
    logic [DATA_W-1:0] opcode_d, opcode_q;
    logic [DATA_W-1:0] arg_d,    arg_q;
    logic              len_d,    len_q;
    logic [ADDR_W-1:0] ipc_d,    ipc_q;
    logic              valid_d,  valid_q;
    logic              halted_d, halted_q;
    logic              fault_d,  fault_q;

    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic              pc_wrap;

    ifetch_pc_reg #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_addr(redirect_addr),
        .inc      (pc_inc),
        .pc       (pc),
        .wrap     (pc_wrap)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        arg_d    = arg_q;
        len_d    = len_q;
        ipc_d    = ipc_q;
        fault_d  = fault_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (run) begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH_OP;
                end else begin
                    opcode_d = imem_data;
                    ipc_d    = pc;
                    pc_inc   = 1'b1;
                    if (TRAP_EN && pc_wrap) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else if (is_two_byte(imem_data[7:0])) begin
                        state_d = ST_FETCH_ARG;
                    end else begin
                        arg_d   = '0;
                        len_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FETCH_ARG: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH_OP;
                end else begin
                    pc_inc = 1'b1;
                    if (TRAP_EN && pc_wrap) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        arg_d   = imem_data;
                        len_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A redirect coinciding with a handshake still consumes the
                // instruction; the redirect target (and not HALT) wins.
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH_OP;
                end else if (inst_ready) begin
                    if ((opcode_q & HALT_MASK) == (HALT_OPCODE & HALT_MASK)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH_OP;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d  = (state_d == ST_ISSUE);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            arg_q    <= '0;
            len_q    <= 1'b0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            arg_q    <= arg_d;
            len_q    <= len_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign imem_addr    = pc;
    assign inst_valid   = valid_q;
    assign inst_opcode  = opcode_q;
    assign inst_operand = arg_q;
    assign inst_len     = len_q;
    assign inst_pc      = ipc_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb_ifetch_sequencer
//   Scoreboard bench for ifetch_sequencer: an instruction-level model walks
//   the ROM image and queues the expected instruction stream; a monitor pops
//   and compares on every handshake.
module tb_ifetch_sequencer;

`ifdef IFETCH_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [4:0] imem_addr;
    logic [7:0] imem_data;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] inst_opcode;
    logic [7:0] inst_operand;
    logic       inst_len;
    logic [4:0] inst_pc;
    logic       redirect_valid;
    logic [4:0] redirect_addr;
    logic       halted;
    logic       fault;

    logic [7:0] rom [32];

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic       len;
        logic [4:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   cyc;
    int   checks;
    int   failures;
    bit   halt_pending;
    exp_t mon_e;

    ifetch_sequencer #(
        .ADDR_W     (5),
        .DATA_W     (8),
        .HALT_OPCODE(8'h10),
        .HALT_MASK  (8'hF0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_opcode   (inst_opcode),
        .inst_operand  (inst_operand),
        .inst_len      (inst_len),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halted        (halted),
        .fault         (fault)
    );

    assign imem_data = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted instruction against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            halt_pending = 1'b0;
        end else begin
            if (halt_pending) begin
                check("halt_next_halted", {31'd0, halted}, 32'd1);
                check("halt_next_valid", {31'd0, inst_valid}, 32'd0);
                halt_pending = 1'b0;
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got op=%0h pc=%0h expected none",
                             inst_opcode, inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue_opcode", {24'd0, inst_opcode}, {24'd0, mon_e.op});
                    check("issue_operand", {24'd0, inst_operand}, {24'd0, mon_e.arg});
                    check("issue_len", {31'd0, inst_len}, {31'd0, mon_e.len});
                    check("issue_pc", {27'd0, inst_pc}, {27'd0, mon_e.pc});
                    hs_cyc.push_back(cyc);
                    if (mon_e.op >= 8'h10 && mon_e.op <= 8'h1F && !redirect_valid)
                        halt_pending = 1'b1;
                end
            end
        end
    end

    // Instruction-level reference: walks the ROM from start, pushing expected
    // instructions. outcome: 0 = limit reached, 1 = HALT, 2 = wrap trap.
    task automatic model_run(input int start, input int max_n, output int outcome);
        int p;
        exp_t e;
        logic [7:0] b;
        p = start;
        outcome = 0;
        for (int n = 0; n < max_n; n++) begin
            if (TRAP && p == 31) begin outcome = 2; return; end
            b = rom[p];
            e.op = b;
            e.pc = p[4:0];
            p = (p + 1) % 32;
            if (b >= 8'h20 && b <= 8'h3F) begin
                if (TRAP && p == 31) begin outcome = 2; return; end
                e.arg = rom[p];
                e.len = 1'b1;
                p = (p + 1) % 32;
            end else begin
                e.arg = 8'h00;
                e.len = 1'b0;
            end
            exp_q.push_back(e);
            if (b >= 8'h10 && b <= 8'h1F) begin outcome = 1; return; end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        run            = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        inst_ready     = 1'b0;
        tick(2);
        exp_q.delete();
        hs_cyc.delete();
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    // Set start PC through an IDLE redirect, then pulse run.
    task automatic start(input logic [4:0] pc);
        redirect_valid = 1'b1;
        redirect_addr  = pc;
        tick(1);
        redirect_valid = 1'b0;
        run            = 1'b1;
        tick(1);
        run            = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!inst_valid && n < budget) begin tick(1); n++; end
        check(name, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic wait_halted(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin tick(1); n++; end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic drain(input int budget, input bit rnd, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            inst_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(1);
            n++;
        end
        inst_ready = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int outcome;
        int start_pc;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        halt_pending = 1'b0;
        fill_rom(8'h80);
        do_reset();

        // Reset state
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_opcode", {24'd0, inst_opcode}, 32'd0);
        check("rst_operand", {24'd0, inst_operand}, 32'd0);
        check("rst_len", {31'd0, inst_len}, 32'd0);
        check("rst_pc", {27'd0, inst_pc}, 32'd0);
        check("rst_addr", {27'd0, imem_addr}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Two-byte then one-byte, full-rate ready: issues two cycles apart
        fill_rom(8'h80);
        rom[0] = 8'h3C; rom[1] = 8'h00; rom[2] = 8'h70; rom[3] = 8'h10;
        model_run(0, 10, outcome);
        start(5'd0);
        drain(50, 1'b0, "t1_drain");
        check("t1_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("t1_gap_a", hs_cyc[1] - hs_cyc[0], 2);
            check("t1_gap_b", hs_cyc[2] - hs_cyc[1], 2);
        end
        tick(1);
        check("t1_halted", {31'd0, halted}, 32'd1);

        // Back-pressure: everything stable while ready is low
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h45; rom[1] = 8'h1F;
        model_run(0, 10, outcome);
        start(5'd0);
        wait_valid(10, "t2_valid");
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_stall_op", {24'd0, inst_opcode}, 32'h45);
            check("t2_stall_len", {31'd0, inst_len}, 32'd0);
            check("t2_stall_pc", {27'd0, inst_pc}, 32'd0);
            check("t2_stall_addr", {27'd0, imem_addr}, 32'd1);
            tick(1);
        end
        drain(50, 1'b0, "t2_drain");

        // Redirect while fetching the operand byte
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h2A; rom[1] = 8'h55; rom[9] = 8'h61; rom[10] = 8'h1F;
        inst_ready = 1'b1;
        start(5'd0);
        tick(1);
        check("t3_arg_addr", {27'd0, imem_addr}, 32'd1);
        redirect_valid = 1'b1;
        redirect_addr  = 5'd9;
        tick(1);
        redirect_valid = 1'b0;
        check("t3_redir_addr", {27'd0, imem_addr}, 32'd9);
        check("t3_redir_valid", {31'd0, inst_valid}, 32'd0);
        model_run(9, 10, outcome);
        drain(50, 1'b0, "t3_drain");

        // HALT at address 4 is sticky against redirect and run
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h80; rom[1] = 8'h81; rom[2] = 8'h82; rom[3] = 8'h83; rom[4] = 8'h1A;
        model_run(0, 10, outcome);
        start(5'd0);
        drain(100, 1'b1, "t4_drain");
        tick(2);
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_valid", {31'd0, inst_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 5'd3;
        run            = 1'b1;
        tick(3);
        redirect_valid = 1'b0;
        run            = 1'b0;
        check("t4_sticky_halted", {31'd0, halted}, 32'd1);
        check("t4_sticky_valid", {31'd0, inst_valid}, 32'd0);
        check("t4_sticky_addr", {27'd0, imem_addr}, 32'd5);

        // Two-byte opcode at the top address
        do_reset();
        fill_rom(8'h80);
        rom[31] = 8'h22; rom[0] = 8'h77; rom[1] = 8'h13;
        model_run(31, 10, outcome);
        start(5'd31);
        if (TRAP) begin
            wait_halted(20, "t5_trap_halted");
            check("t5_trap_fault", {31'd0, fault}, 32'd1);
            check("t5_trap_valid", {31'd0, inst_valid}, 32'd0);
        end else begin
            wait_valid(10, "t5_valid");
            check("t5_next_addr", {27'd0, imem_addr}, 32'd1);
            drain(50, 1'b0, "t5_drain");
            check("t5_fault", {31'd0, fault}, 32'd0);
        end

        // Asynchronous reset in ISSUE
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h50;
        start(5'd0);
        wait_valid(10, "t6_valid");
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, inst_valid}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t6_addr", {27'd0, imem_addr}, 32'd0);
        check("t6_halted", {31'd0, halted}, 32'd0);
        check("t6_opcode", {24'd0, inst_opcode}, 32'd0);
        tick(3);
        check("t6_idle_valid", {31'd0, inst_valid}, 32'd0);

        // Random programs, start addresses and ready patterns
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
            start_pc = $urandom_range(0, 31);
            model_run(start_pc, 20, outcome);
            start(start_pc[4:0]);
            drain(400, 1'b1, "rnd_drain");
            tick(2);
            if (outcome == 1) begin
                check("rnd_halted", {31'd0, halted}, 32'd1);
            end else if (outcome == 2) begin
                wait_halted(20, "rnd_trap_halted");
                check("rnd_trap_fault", {31'd0, fault}, 32'd1);
            end else begin
                check("rnd_not_halted", {31'd0, halted}, 32'd0);
            end
            if (!TRAP) check("rnd_fault_zero", {31'd0, fault}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_sequencer.md
Name: ifetch_sequencer

Overview:
- Fetch controller for the 32 x 8 instruction ROM (5-bit address, combinational 8-bit read data).
- Owns the program counter and drives the ROM address.
- Assembles one-byte and two-byte instructions (opcode plus operand) and presents each one to the decoder over a valid/ready handshake.
- Accepts PC redirects from execute (jumps/branches) and stops at a HALT opcode.

Parameters:
- ADDR_W, 5, ROM address / PC width.
- DATA_W, 8, ROM word width.
- HALT_OPCODE, 8'h10, value that halts fetch when compared under HALT_MASK.
- HALT_MASK, 8'hF0, bits of the opcode compared against HALT_OPCODE; don't-care operand nibble is ignored.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  start fetching from the current PC (level-sensitive, sampled in IDLE).
- imem_addr  output  ADDR_W  ROM address.
- imem_data  input  DATA_W  ROM read data, combinational from imem_addr.
- inst_valid  output  1  instruction presented.
- inst_ready  input  1  decoder accepts the instruction.
- inst_opcode  output  DATA_W  first instruction byte.
- inst_operand  output  DATA_W  second byte; 0 for one-byte instructions.
- inst_len  output  1  0 = one byte, 1 = two bytes.
- inst_pc  output  ADDR_W  address of the opcode byte.
- redirect_valid  input  1  load a new PC.
- redirect_addr  input  ADDR_W  target PC.
- halted  output  1  HALT state reached.
- fault  output  1  PC wrap trap (see Optional Feature; tied 0 when the feature is compiled out).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n=0 forces:
  - pc=0, state=IDLE;
  - inst_valid=0, inst_opcode=0, inst_operand=0, inst_len=0, inst_pc=0;
  - halted=0, fault=0.
  - Reset mid-instruction discards all in-flight state.
- imem_addr = pc in every state. ROM data is sampled at the clock edge of the state that uses it.
- Length rule: two-byte when opcode[7:5]==3'b001 (0x20..0x3F); all other opcodes are one-byte.
- State IDLE:
  - redirect_valid loads pc<=redirect_addr and stays in IDLE (this is how the start address is set).
  - run=1 goes to FETCH_OP.
- State FETCH_OP:
  - Capture inst_opcode<=imem_data and inst_pc<=pc; pc<=pc+1.
  - Two-byte opcode goes to FETCH_ARG.
  - One-byte opcode sets inst_operand<=0, inst_len<=0 and goes to ISSUE.
- State FETCH_ARG: capture inst_operand<=imem_data, inst_len<=1, pc<=pc+1, go to ISSUE.
- State ISSUE:
  - inst_valid=1. Opcode, operand, len and pc stay stable until the handshake (inst_valid & inst_ready).
  - On handshake: (opcode & HALT_MASK)==(HALT_OPCODE & HALT_MASK) goes to HALT; otherwise go to FETCH_OP.
  - inst_valid is deasserted in the cycle after the handshake.
- State HALT: halted=1, inst_valid=0. Sticky until reset; run and redirect are ignored.
- Latency: entering FETCH_OP to inst_valid is 1 cycle (one-byte) or 2 cycles (two-byte). Peak throughput is one instruction per 2 or 3 cycles.
- Redirect in FETCH_OP, FETCH_ARG or ISSUE:
  - pc<=redirect_addr, next state is FETCH_OP, partial fetch discarded, inst_valid=0 next cycle.
  - Simultaneous with a handshake in ISSUE: the instruction counts as consumed and the redirect target wins.
  - Redirect also overrides a HALT opcode being accepted in the same cycle.
- PC arithmetic is modulo 2^ADDR_W: 31+1 = 0. A two-byte opcode at address 31 takes its operand from address 0.
- inst_ready while inst_valid=0 is ignored.

Optional Feature:
- Macro: IFETCH_WRAP_TRAP_EN.
- Defined: any pc increment from 31 to 0 (in FETCH_OP or FETCH_ARG) sends the block to HALT the next cycle with fault=1 and halted=1. The partially fetched instruction is not issued. fault clears only on reset.
- Undefined: wrap is silent as described above; fault is tied to 0.

Decomposition:
- Shared package ifetch_pkg holds:
  - state encoding (IDLE, FETCH_OP, FETCH_ARG, ISSUE, HALT);
  - the LONG_OP prefix constant 3'b001;
  - default HALT_OPCODE/HALT_MASK constants;
  - an is_two_byte(opcode) function.
- Natural sub-module: ifetch_pc_reg (PC register with load/increment/wrap output), instantiated once.

Test Plan:
- ROM[0]=8'h3C, ROM[1]=8'h00, ROM[2]=8'h70, inst_ready=1, run=1 -> first issue opcode 3C, operand 00, len 1, pc 0; next issue 70, len 0, pc 2 two cycles later.
- inst_ready held 0 for 5 cycles in ISSUE -> inst_valid stays 1, all inst_* fields unchanged, imem_addr static.
- redirect_valid with redirect_addr=5'd9 during FETCH_ARG -> next instruction issued has inst_pc=9; the operand in flight is never presented.
- ROM[4]=8'h1x (HALT) accepted -> halted=1 next cycle, inst_valid=0 thereafter; a later redirect does not clear it.
- Two-byte opcode 8'h22 at address 31, wrap trap off -> operand = ROM[0], next pc=1. With IFETCH_WRAP_TRAP_EN -> fault=1, halted=1, no issue.
- rst_n pulsed low asynchronously mid-ISSUE -> inst_valid drops immediately; after release pc=0, state IDLE, halted=0.
